// File: rtl/hex_entry_pkg.sv
// Shared types and constants for the keypad hex-entry controller.
package hex_entry_pkg;

  localparam int DIGW = 4;
  localparam int NKEY = 19;

  typedef enum logic [1:0] {
    EMPTY,
    ENTRY,
    FULL,
    SUBMIT
  } state_t;

  typedef enum logic [2:0] {
    EV_NONE,
    EV_HEX,
    EV_BKSP,
    EV_ENTER,
    EV_CLR
  } ev_t;

endpackage

// File: rtl/key_event.sv
// Registers the 19 key lines, detects a fresh press from an all-idle sample
// and resolves simultaneous lines to a single prioritised event.
module key_event
  import hex_entry_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] keys,
  input  logic        bksp,
  input  logic        enter,
  input  logic        clr,
  output ev_t         ev,
  output logic [3:0]  hex
);

  logic [NKEY-1:0] ksync;
  logic [NKEY-1:0] kprev;
  logic            fire;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ksync <= '0;
      kprev <= '0;
    end else begin
      ksync <= {clr, enter, bksp, keys};
      kprev <= ksync;
    end
  end

  // Only a transition out of an all-released sample counts, so extra keys
  // joining an already-held chord never create a second event.
  assign fire = (|ksync) & ~(|kprev);

  always_comb begin
    ev  = EV_NONE;
    hex = '0;
    if (fire) begin
      if (ksync[18])      ev = EV_CLR;
      else if (ksync[17]) ev = EV_ENTER;
      else if (ksync[16]) ev = EV_BKSP;
      else begin
        ev = EV_HEX;
        for (int i = 0; i < 16; i++) begin
          if (ksync[i]) hex = 4'(i);
        end
      end
    end
  end

endmodule

// File: rtl/hex_entry_ctrl.sv
// Hex digit entry buffer with backspace, clear and a valid/ready submit port,
// fed by prioritised key events from key_event.
module hex_entry_ctrl
  import hex_entry_pkg::*;
#(
  parameter int NDIG = 8
) (
  input  logic        hz100,
  input  logic        reset,
  input  logic [15:0] keys,
  input  logic        bksp,
  input  logic        enter,
  input  logic        clr,
  output logic [31:0] disp_data,
  output logic [7:0]  digit_en,
  output logic [3:0]  count,
  output logic [15:0] bar,
  output logic        err,
  output logic [31:0] out_data,
  output logic        out_valid,
  input  logic        out_ready
);

  localparam logic [3:0]  NDIG_C   = 4'(NDIG);
  localparam logic [31:0] DIG_MASK = 32'((64'd1 << (DIGW * NDIG)) - 64'd1);

  state_t      state;
  logic [31:0] buf_q;
  logic [3:0]  cnt;
  ev_t         ev;
  logic [3:0]  hex;
  logic [31:0] pushed;
  logic [31:0] popped;

  key_event u_keys (
    .clk   (hz100),
    .rst_n (reset),
    .keys  (keys),
    .bksp  (bksp),
    .enter (enter),
    .clr   (clr),
    .ev    (ev),
    .hex   (hex)
  );

  assign pushed = {buf_q[31-DIGW:0], hex} & DIG_MASK;
  assign popped = {{DIGW{1'b0}}, buf_q[31:DIGW]};

  // Clear outranks everything, including a handshake completing on the same edge.
  always_ff @(posedge hz100 or negedge reset) begin
    if (!reset) begin
      state     <= EMPTY;
      buf_q     <= '0;
      cnt       <= '0;
      err       <= 1'b0;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else begin
      err <= 1'b0;
      if (ev == EV_CLR) begin
        state     <= EMPTY;
        buf_q     <= '0;
        cnt       <= '0;
        out_valid <= 1'b0;
      end else begin
        case (state)
          EMPTY: begin
            if (ev == EV_HEX) begin
              buf_q <= pushed;
              cnt   <= cnt + 4'd1;
              state <= (NDIG_C == 4'd1) ? FULL : ENTRY;
            end else if (ev == EV_BKSP || ev == EV_ENTER) begin
              err <= 1'b1;
            end
          end
          ENTRY: begin
            if (ev == EV_HEX) begin
              buf_q <= pushed;
              cnt   <= cnt + 4'd1;
              state <= (cnt == NDIG_C - 4'd1) ? FULL : ENTRY;
            end else if (ev == EV_BKSP) begin
              buf_q <= popped;
              cnt   <= cnt - 4'd1;
              state <= (cnt == 4'd1) ? EMPTY : ENTRY;
            end else if (ev == EV_ENTER) begin
              out_data  <= buf_q;
              out_valid <= 1'b1;
              state     <= SUBMIT;
            end
          end
          FULL: begin
            if (ev == EV_HEX) begin
              err <= 1'b1;
            end else if (ev == EV_BKSP) begin
              buf_q <= popped;
              cnt   <= cnt - 4'd1;
              state <= (cnt == 4'd1) ? EMPTY : ENTRY;
            end else if (ev == EV_ENTER) begin
              out_data  <= buf_q;
              out_valid <= 1'b1;
              state     <= SUBMIT;
            end
          end
          SUBMIT: begin
            if (out_ready) begin
              out_valid <= 1'b0;
              buf_q     <= '0;
              cnt       <= '0;
              state     <= EMPTY;
            end
          end
        endcase
      end
    end
  end

  assign disp_data = buf_q;
  assign count     = cnt;

  always_comb begin
    digit_en = '0;
    bar      = '0;
    for (int i = 0; i < 8; i++) begin
      digit_en[i] = (i < int'(cnt));
    end
    for (int i = 0; i < 16; i++) begin
      bar[i] = (i < 2 * int'(cnt));
    end
  end

endmodule

// File: tb/tb_hex_entry_ctrl.sv
// Self-checking bench for hex_entry_ctrl: directed scenarios followed by
// randomized key sequences compared against a queue-based entry model.
module tb_hex_entry_ctrl;

  localparam int NDIG = 8;
  localparam logic [18:0] P_BKSP  = 19'h10000;
  localparam logic [18:0] P_ENTER = 19'h20000;
  localparam logic [18:0] P_CLR   = 19'h40000;

  logic        hz100;
  logic        reset;
  logic [18:0] pat;
  logic        out_ready;
  logic [31:0] disp_data;
  logic [7:0]  digit_en;
  logic [3:0]  count;
  logic [15:0] bar;
  logic        err;
  logic [31:0] out_data;
  logic        out_valid;

  int passed;
  int failed;
  int total;
  int err_seen;
  int err_exp;

  int          q[$];
  bit          pending;
  logic [31:0] m_out;

  hex_entry_ctrl #(.NDIG(NDIG)) dut (
    .hz100     (hz100),
    .reset     (reset),
    .keys      (pat[15:0]),
    .bksp      (pat[16]),
    .enter     (pat[17]),
    .clr       (pat[18]),
    .disp_data (disp_data),
    .digit_en  (digit_en),
    .count     (count),
    .bar       (bar),
    .err       (err),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial begin
    hz100 = 1'b0;
    forever #5 hz100 = ~hz100;
  end

  always @(negedge hz100) begin
    if (err === 1'b1) err_seen++;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation exceeded time limit");
    $fatal(1, "[TB] timeout");
  end

  function automatic logic [18:0] hexpat(input int d);
    logic [18:0] one;
    one = 19'd1;
    return one << d;
  endfunction

  function automatic logic [31:0] model_value();
    logic [31:0] v;
    v = '0;
    foreach (q[i]) v = (v << 4) | 32'(q[i]);
    return v;
  endfunction

  // Apply one recognised key event to the abstract entry model.
  task automatic model_event(input logic [18:0] p);
    int d;
    if (p[18]) begin
      q.delete();
      pending = 0;
    end else if (pending) begin
    end else if (p[17]) begin
      if (q.size() == 0) err_exp++;
      else begin
        m_out   = model_value();
        pending = 1;
      end
    end else if (p[16]) begin
      if (q.size() == 0) err_exp++;
      else void'(q.pop_back());
    end else begin
      d = -1;
      for (int i = 15; i >= 0; i--) begin
        if (p[i] && d < 0) d = i;
      end
      if (q.size() == NDIG) err_exp++;
      else q.push_back(d);
    end
  endtask

  task automatic check(input string tag, input string field,
                       input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("[TB] FAIL %s.%s observed=%h expected=%h", tag, field, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag);
    int n;
    n = q.size();
    check(tag, "disp_data", disp_data, model_value());
    check(tag, "count", 32'(count), 32'(n));
    check(tag, "digit_en", 32'(digit_en), (32'd1 << n) - 32'd1);
    check(tag, "bar", 32'(bar), (32'd1 << (2 * n)) - 32'd1);
    check(tag, "out_valid", 32'(out_valid), 32'(pending));
    check(tag, "out_data", out_data, m_out);
    check(tag, "err_pulses", 32'(err_seen), 32'(err_exp));
  endtask

  task automatic applyStimulus(input logic [18:0] p, input int hold, input int rel);
    @(negedge hz100);
    pat = p;
    repeat (hold) @(negedge hz100);
    pat = '0;
    repeat (rel) @(negedge hz100);
    if (p != '0) model_event(p);
  endtask

  task automatic handshake(input string tag);
    @(negedge hz100);
    out_ready = 1'b1;
    @(posedge hz100);
    #1;
    if (pending) begin
      pending = 0;
      q.delete();
    end
    checkOutput(tag);
    @(negedge hz100);
    out_ready = 1'b0;
  endtask

  initial begin
    int r;
    logic [18:0] p;
    passed = 0; failed = 0; total = 0;
    err_seen = 0; err_exp = 0;
    pending = 0; m_out = '0;
    pat = '0;
    out_ready = 1'b0;
    reset = 1'b1;
    #1 reset = 1'b0;
    repeat (2) @(negedge hz100);
    checkOutput("reset");
    reset = 1'b1;

    applyStimulus(hexpat(1), 3, 2);
    applyStimulus(hexpat(2), 3, 2);
    applyStimulus(hexpat(3), 3, 2);
    check("t1", "disp_lit", disp_data, 32'h00000123);
    checkOutput("t1");

    applyStimulus(P_CLR, 2, 2);
    for (int d = 0; d < 8; d++) applyStimulus(hexpat(d), 2, 2);
    check("t2", "disp_lit", disp_data, 32'h01234567);
    check("t2", "bar_lit", 32'(bar), 32'h0000FFFF);
    checkOutput("t2_full");
    applyStimulus(hexpat(8), 2, 2);
    checkOutput("t2_overflow");

    applyStimulus(P_CLR, 2, 2);
    for (int d = 1; d <= 3; d++) applyStimulus(hexpat(d), 2, 2);
    applyStimulus(P_BKSP, 2, 2);
    check("t3", "disp_lit", disp_data, 32'h00000012);
    applyStimulus(P_BKSP, 2, 2);
    applyStimulus(P_BKSP, 2, 2);
    checkOutput("t3_empty");
    applyStimulus(P_BKSP, 2, 2);
    checkOutput("t3_err");

    applyStimulus(hexpat(10), 2, 2);
    applyStimulus(hexpat(11), 2, 2);
    applyStimulus(P_ENTER, 2, 2);
    for (int c = 0; c < 5; c++) begin
      @(negedge hz100);
      check("t4_hold", "out_valid", 32'(out_valid), 32'd1);
      check("t4_hold", "out_data", out_data, 32'h000000AB);
    end
    applyStimulus(hexpat(5), 2, 2);
    checkOutput("t4_ignored");
    handshake("t4_accept");
    checkOutput("t4_after");

    applyStimulus(hexpat(1), 2, 2);
    applyStimulus(hexpat(3) | hexpat(7) | P_BKSP, 2, 2);
    checkOutput("t5_prio");
    applyStimulus(hexpat(7), 20, 2);
    checkOutput("t5_hold");

    @(negedge hz100);
    pat = hexpat(3);
    repeat (2) @(negedge hz100);
    pat = hexpat(3) | hexpat(9);
    repeat (2) @(negedge hz100);
    pat = '0;
    repeat (2) @(negedge hz100);
    model_event(hexpat(3));
    checkOutput("t5_chord");

    applyStimulus(P_ENTER, 2, 2);
    checkOutput("t6_submit");
    @(negedge hz100);
    pat = P_CLR;
    @(negedge hz100);
    out_ready = 1'b1;
    check("t6_pre", "out_valid", 32'(out_valid), 32'd1);
    @(posedge hz100);
    #1;
    model_event(P_CLR);
    check("t6_clr", "out_valid", 32'(out_valid), 32'd0);
    check("t6_clr", "count", 32'(count), 32'd0);
    @(negedge hz100);
    pat = '0;
    out_ready = 1'b0;
    repeat (2) @(negedge hz100);
    checkOutput("t6_after");

    applyStimulus(hexpat(4), 2, 2);
    applyStimulus(hexpat(6), 2, 2);
    @(negedge hz100);
    #2 reset = 1'b0;
    #1;
    q.delete();
    pending = 0;
    m_out = '0;
    checkOutput("t6_reset");
    check("t6_reset", "err", 32'(err), 32'd0);
    @(negedge hz100);
    reset = 1'b1;

    for (int it = 0; it < 80; it++) begin
      r = int'($urandom_range(0, 9));
      case (r)
        5:       p = P_BKSP;
        6:       p = P_ENTER;
        7:       p = P_CLR;
        8: begin
          p = 19'($urandom);
          if (p == '0) p = hexpat(0);
        end
        default: p = hexpat(int'($urandom_range(0, 15)));
      endcase
      if (r == 9) handshake("rand_hs");
      else applyStimulus(p, int'($urandom_range(1, 4)), int'($urandom_range(2, 3)));
      checkOutput("rand");
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/hex_entry_ctrl.md
Name: hex_entry_ctrl

Overview:
Keypad entry controller for the lab board. It turns pushbutton presses into an 8-digit hexadecimal entry buffer, with backspace, clear and submit.
- Provides nibble data and a digit-enable mask for the seven-segment decoders.
- Drives a bargraph fill level on {left,right}.
- Hands the completed value downstream on a valid/ready handshake.
- Sits between the pb[] inputs and the ss7..ss0/left/right datapath in top.

Parameters:
NDIG, 8, number of buffered hex digits (legal 1..8)

Ports:
hz100      in   1   system clock (100 Hz board clock)
reset      in   1   asynchronous active-low reset; asserted when 0
keys       in   16  hex keys, keys[i] = digit i (pb[15:0])
bksp       in   1   backspace key
enter      in   1   submit key
clr        in   1   clear key
disp_data  out  32  buffer; [3:0] = most recent digit (rightmost, ss0)
digit_en   out  8   bit i = 1 iff i < count (blanks unused digits)
count      out  4   digits held, 0..NDIG
bar        out  16  {left,right}; low 2*count bits set, rest 0
err        out  1   one-cycle pulse on a rejected key event
out_data   out  32  submitted value; stable while out_valid
out_valid  out  1   submitted value available
out_ready  in   1   downstream accepts out_data

Behaviour:
- Reset (reset=0, async): disp_data=0, count=0, digit_en=0, bar=0, err=0, out_data=0, out_valid=0. Input sample registers clear. State EMPTY.
- Input sampling: all 19 key lines are registered into ksync every edge. The previous ksync is held in kprev.
- Event generation: an event fires when (|ksync) & ~(|kprev).
  - A held key gives exactly one event.
  - All keys must read 0 for at least one sample before the next event.
  - A second key pressed while another is held is ignored.
- Event priority when lines are simultaneous: clr > enter > bksp > hex. Among hex keys, the highest index wins.
- Latency: a key asserted before edge k lands in ksync at edge k. The state/buffer/err update happens at edge k+1.
- States:
  - EMPTY (count=0).
  - ENTRY (0<count<NDIG).
  - FULL (count=NDIG).
  - SUBMIT (out_valid=1).
- Hex d:
  - EMPTY/ENTRY: disp_data <= {disp_data[27:0], d}, count+1. Go to FULL when count reaches NDIG, else ENTRY.
  - FULL: no change, err pulse.
  - SUBMIT: ignored, no err.
- bksp:
  - ENTRY/FULL: disp_data <= {4'h0, disp_data[31:4]}, count-1. Go to EMPTY when count reaches 0, else ENTRY.
  - EMPTY: err pulse.
  - SUBMIT: ignored.
- enter:
  - ENTRY/FULL: out_data <= disp_data, out_valid <= 1, go to SUBMIT.
  - EMPTY: err pulse.
  - SUBMIT: ignored.
- SUBMIT:
  - On an edge with out_valid & out_ready: out_valid <= 0, disp_data <= 0, count <= 0, go to EMPTY.
  - out_data holds its last value after handshake.
  - out_ready while out_valid=0 has no effect.
- clr, in any state: disp_data <= 0, count <= 0, out_valid <= 0, go to EMPTY. No err. In SUBMIT this withdraws the pending value, even on an edge where out_ready=1; clr wins.
- Widths:
  - Bits of disp_data above 4*NDIG stay 0.
  - bar = (2*count) low ones; count=8 gives 16'hFFFF.
- Reset asserted mid-entry or mid-submit returns to the reset values immediately. No partial handshake completes.

Decomposition:
- Package hex_entry_pkg:
  - state enum {EMPTY, ENTRY, FULL, SUBMIT}.
  - Event enum {EV_NONE, EV_HEX, EV_BKSP, EV_ENTER, EV_CLR}.
  - Constant DIGW=4.
- Sub-module key_event:
  - Contains the ksync/kprev registers, the edge detect and the priority encoder.
  - Outputs: ev (event enum) and hex (4-bit).
- The top-level FSM/buffer lives in hex_entry_ctrl.
- Seven-segment decoding stays in the existing decoder instances, outside this block.

Test Plan:
1. Reset, then press keys 1,2,3 (each held 3 cycles, released 2) -> disp_data=32'h00000123, count=3, digit_en=8'h07, bar=16'h003F, err never 1.
2. Enter 9 digits 0..8 -> after 8th: count=8, disp_data=32'h01234567, bar=16'hFFFF. The 9th digit gives one err pulse and no data change.
3. From 32'h123 (count=3): bksp -> 32'h12, count=2. Two more bksp -> count=0, EMPTY. A 4th bksp -> err pulse.
4. Enter A,B then enter with out_ready=0 for 5 cycles:
   - out_valid=1, out_data=32'hAB, stable.
   - Key 5 pressed meanwhile is ignored.
   - Raise out_ready -> out_valid=0 next edge, count=0, disp_data=0.
5. Press keys 3 and 7 together with bksp -> bksp wins. Hold key 7 for 20 cycles -> exactly one insertion of 7.
6. clr during SUBMIT with out_ready=1 on the same edge -> out_valid=0, count=0. Async reset mid-entry -> all outputs 0 before the next edge.
